// File: rtl/bram_read_arbiter_if.sv
// Bus bundle between the image-side requesters, the read-port arbiter and the
// BRAM read port.
//   arb_en     : 1 = arbiter may issue new grants
//   req/lock   : per-requester read request and ownership-hold flags
//   req_addr   : per-requester read address, slice i belongs to requester i
//   gnt        : one-hot grant; a transfer happens when req[i] & gnt[i]
//   bram_en    : BRAM read enable
//   bram_addr  : BRAM read address
//   bram_dout  : BRAM read data
//   rvalid     : one-hot, read data valid for requester i
//   rdata      : read data returned to the requester flagged in rvalid
//   busy       : arbiter locked or reads still in flight
// master: requester/BRAM side. slave: arbiter side.
interface bram_read_arbiter_if #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 19,
   parameter int NUM_REQ    = 4
);
   logic                           arb_en;
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             lock;
   logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
   logic [NUM_REQ-1:0]             gnt;
   logic                           bram_en;
   logic [ADDR_WIDTH-1:0]          bram_addr;
   logic [DATA_WIDTH-1:0]          bram_dout;
   logic [NUM_REQ-1:0]             rvalid;
   logic [DATA_WIDTH-1:0]          rdata;
   logic                           busy;

   modport master (
      output arb_en, req, lock, req_addr, bram_dout,
      input  gnt, bram_en, bram_addr, rvalid, rdata, busy
   );

   modport slave (
      input  arb_en, req, lock, req_addr, bram_dout,
      output gnt, bram_en, bram_addr, rvalid, rdata, busy
   );
endinterface

// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing the single BRAM read port between NUM_REQ
// requesters. A requester may lock ownership across a burst (up to MAX_LOCK
// transfers). Read data comes back tagged with the owner's one-hot rvalid,
// 2+RD_LAT cycles after the transfer, in issue order.
// Ports:
//   clk_p : clock
//   rst   : synchronous active-high reset
//   bus   : slave side of bram_read_arbiter_if (requests, grants, BRAM port,
//           tagged read data, busy)
module bram_read_arbiter #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 19,
   parameter int NUM_REQ    = 4,
   parameter int RD_LAT     = 1,
   parameter int MAX_LOCK   = 16
) (
   input  logic               clk_p,
   input  logic               rst,
   bram_read_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   // Count value at which one more locked transfer forces release.
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             state_reg;
   logic [IDX_W-1:0]   rr_reg;
   logic [IDX_W-1:0]   owner_reg;
   logic [CNT_W-1:0]   lock_cnt_reg;

   // First set request at or above ptr, wrapping. Result is {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDX_W-1:0]   ptr);
      logic             found;
      logic [IDX_W-1:0] w;
      int               j;
      found = 1'b0;
      w     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && r[j]) begin
            found = 1'b1;
            w     = IDX_W'(j);
         end
      end
      return {found, w};
   endfunction

   // Per-requester address slices.
   logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
   end

   logic [IDX_W:0]     pick;
   logic               winner_found;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   winner_inc;
   logic [NUM_REQ-1:0] grant;
   logic               xfer;
   logic [IDX_W-1:0]   xfer_idx;

   assign pick         = rr_pick(bus.req, rr_reg);
   assign winner_found = pick[IDX_W];
   assign winner       = pick[IDX_W-1:0];
   assign winner_inc   = (winner == IDX_LAST) ? '0 : winner + 1'b1;

   // Grant is combinational so a requester can transfer in the same cycle it
   // raises req; a locked owner is the only candidate while LOCKED.
   always_comb begin
      grant = '0;
      if (!rst && bus.arb_en) begin
         if (state_reg == LOCKED) begin
            grant[owner_reg] = bus.req[owner_reg];
         end else if (winner_found) begin
            grant[winner] = 1'b1;
         end
      end
   end

   assign xfer_idx = (state_reg == LOCKED) ? owner_reg : winner;
   assign xfer     = |(grant & bus.req);
   assign bus.gnt  = grant;

   // Ownership FSM. With arb_en low nothing moves, including a lock release.
   always_ff @(posedge clk_p) begin
      if (rst) begin
         state_reg    <= IDLE;
         rr_reg       <= '0;
         owner_reg    <= '0;
         lock_cnt_reg <= '0;
      end else if (bus.arb_en) begin
         case (state_reg)
            IDLE: begin
               if (xfer) begin
                  rr_reg <= winner_inc;
                  // A single-transfer lock limit never holds ownership.
                  if (bus.lock[winner] && (MAX_LOCK > 1)) begin
                     state_reg    <= LOCKED;
                     owner_reg    <= winner;
                     lock_cnt_reg <= CNT_W'(1);
                  end
               end
            end
            LOCKED: begin
               // rr_reg already points past the owner from the locking grant.
               if (xfer) begin
                  if (!bus.lock[owner_reg] || (lock_cnt_reg == LOCK_LAST)) begin
                     state_reg <= IDLE;
                  end
                  lock_cnt_reg <= lock_cnt_reg + 1'b1;
               end else if (!bus.lock[owner_reg]) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Read datapath: address stage, then an owner-tag pipeline that lines up
   // with the BRAM latency so returning data can be steered to its requester.
   logic                  bram_en_reg;
   logic [ADDR_WIDTH-1:0] bram_addr_reg;
   logic [RD_LAT:0]       tag_valid_reg;
   logic [IDX_W-1:0]      tag_idx_reg [RD_LAT+1];
   logic [NUM_REQ-1:0]    rvalid_next;
   logic [NUM_REQ-1:0]    rvalid_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
      assign rvalid_next[gi] = tag_valid_reg[RD_LAT] &&
                               (tag_idx_reg[RD_LAT] == IDX_W'(gi));
   end

   always_ff @(posedge clk_p) begin
      if (rst) begin
         bram_en_reg   <= 1'b0;
         bram_addr_reg <= '0;
         tag_valid_reg <= '0;
         rvalid_reg    <= '0;
         rdata_reg     <= '0;
      end else begin
         bram_en_reg <= xfer;
         if (xfer) bram_addr_reg <= addr_arr[xfer_idx];
         tag_valid_reg <= {tag_valid_reg[RD_LAT-1:0], xfer};
         rvalid_reg    <= rvalid_next;
         if (tag_valid_reg[RD_LAT]) rdata_reg <= bus.bram_dout;
      end
   end

   // Tag contents only matter where the matching valid bit is set.
   always_ff @(posedge clk_p) begin
      tag_idx_reg[0] <= xfer_idx;
      for (int k = 1; k <= RD_LAT; k++) begin
         tag_idx_reg[k] <= tag_idx_reg[k-1];
      end
   end

   assign bus.bram_en   = bram_en_reg;
   assign bus.bram_addr = bram_addr_reg;
   assign bus.rvalid    = rvalid_reg;
   assign bus.rdata     = rdata_reg;
   assign bus.busy      = (state_reg == LOCKED) || (|tag_valid_reg);
endmodule

// File: tb/tb_bram_read_arbiter.sv
// Randomized bench for bram_read_arbiter. A transaction-level model (owner,
// burst count, rotation pointer and a queue of pending returns with their due
// cycle) predicts gnt, the BRAM port, tagged read data and busy every cycle.
module tb_bram_read_arbiter;
   localparam int NR = 4;
   localparam int AW = 19;
   localparam int DW = 12;
   localparam int RL = 1;
   localparam int ML = 16;
   localparam int N_CYC = 1500;

   logic clk_p = 1'b0;
   logic rst;
   always #5 clk_p = ~clk_p;

   bram_read_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

   bram_read_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .RD_LAT(RL), .MAX_LOCK(ML)
   ) dut (
      .clk_p (clk_p),
      .rst   (rst),
      .bus   (bus.slave)
   );

   // Memory contents are a fixed function of the address.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return a[11:0] ^ {a[18:12], 5'b10101};
   endfunction

   // BRAM: data for the address presented RL cycles earlier.
   logic [AW-1:0] bram_pipe [RL];
   always @(posedge clk_p) begin
      bram_pipe[0] <= bus.bram_addr;
      for (int k = 1; k < RL; k++) bram_pipe[k] <= bram_pipe[k-1];
   end
   assign bus.bram_dout = mem_word(bram_pipe[RL-1]);

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask

   typedef struct {
      int            due;
      int            idx;
      logic [DW-1:0] data;
   } ret_t;

   // Model state
   ret_t          ret_q[$];
   bit            m_locked;
   int            m_owner;
   int            m_cnt;
   int            m_rr;
   bit            exp_en;
   logic [AW-1:0] exp_addr;
   bit            post_rst;

   // Requester state
   bit            pend [NR];
   logic [AW-1:0] addr_r [NR];

   initial begin
      logic [NR-1:0] exp_rv;
      logic [NR-1:0] exp_gnt;
      int            widx;
      int            phase;
      int            j;
      ret_t          e;

      rst          = 1'b1;
      bus.arb_en   = 1'b0;
      bus.req      = '0;
      bus.lock     = '0;
      bus.req_addr = '0;
      for (int i = 0; i < NR; i++) begin
         pend[i]   = 1'b0;
         addr_r[i] = '0;
      end
      m_locked = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
      exp_en = 0; exp_addr = '0; post_rst = 1;

      for (cyc = 0; cyc < N_CYC; cyc++) begin
         @(posedge clk_p);
         #1;
         // Registered outputs for this cycle.
         check("bram_en", 32'(bus.bram_en), 32'(exp_en));
         if (exp_en || post_rst) check("bram_addr", 32'(bus.bram_addr), 32'(exp_addr));
         exp_rv = '0;
         if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            e = ret_q.pop_front();
            exp_rv[e.idx] = 1'b1;
            check("rdata", 32'(bus.rdata), 32'(e.data));
            $display("cycle %0d: read return req%0d data %03h", cyc, e.idx, e.data);
         end else if (post_rst) begin
            check("rdata_rst", 32'(bus.rdata), 32'h0);
         end
         check("rvalid", 32'(bus.rvalid), 32'(exp_rv));
         check("busy", 32'(bus.busy), 32'(m_locked || (ret_q.size() > 0)));

         // Drive this cycle's inputs.
         phase = cyc / 500;
         rst = (cyc < 2) || (phase == 2 && $urandom_range(0, 49) == 0);
         bus.arb_en = (phase == 0) ? 1'b1 :
                      (phase == 1) ? ($urandom_range(0, 9) != 0) :
                                     ($urandom_range(0, 9) < 7);
         if (cyc == 2) begin
            pend[0]   = 1'b1;
            addr_r[0] = AW'(5);
         end
         for (int i = 0; i < NR; i++) begin
            if (cyc >= 8 && !pend[i] && $urandom_range(0, 3) != 0) begin
               pend[i]   = 1'b1;
               addr_r[i] = AW'($urandom);
            end
            bus.req[i] = pend[i];
            bus.req_addr[i*AW +: AW] = addr_r[i];
            bus.lock[i] = (phase == 0) ? 1'b0 :
                          (phase == 1) ? ($urandom_range(0, 9) != 0) :
                                         1'($urandom_range(0, 1));
         end
         #1;

         // Expected grant from the ownership/rotation rules.
         widx = -1;
         if (!rst && bus.arb_en) begin
            if (m_locked) begin
               if (bus.req[m_owner]) widx = m_owner;
            end else begin
               for (int k = 0; k < NR; k++) begin
                  j = (m_rr + k) % NR;
                  if (widx < 0 && bus.req[j]) widx = j;
               end
            end
         end
         exp_gnt = '0;
         if (widx >= 0) exp_gnt[widx] = 1'b1;
         check("gnt", 32'(bus.gnt), 32'(exp_gnt));

         // Advance the model to the next cycle.
         if (rst) begin
            m_locked = 0; m_rr = 0; m_cnt = 0;
            ret_q.delete();
            exp_en = 0; exp_addr = '0; post_rst = 1;
         end else begin
            post_rst = 0;
            exp_en   = (widx >= 0);
            if (widx >= 0) begin
               exp_addr = addr_r[widx];
               ret_q.push_back('{due: cyc + 2 + RL, idx: widx, data: mem_word(addr_r[widx])});
               pend[widx] = 1'b0;
            end
            if (bus.arb_en) begin
               if (!m_locked) begin
                  if (widx >= 0) begin
                     m_rr = (widx + 1) % NR;
                     if (bus.lock[widx]) begin
                        m_locked = 1; m_owner = widx; m_cnt = 1;
                     end
                  end
               end else if (widx >= 0) begin
                  if (bus.lock[m_owner]) begin
                     m_cnt++;
                     if (m_cnt == ML) m_locked = 0;
                  end else begin
                     m_locked = 0;
                  end
               end else if (!bus.lock[m_owner]) begin
                  m_locked = 0;
               end
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
